// File: rtl/fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : fetch_ctrl
// Description : Single-outstanding instruction-fetch sequencer. It owns the PC,
//               holds fetched words for decode and applies redirects.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    input  logic        instr_ready,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        fetch_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        HOLD = 2'd3
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] instr_pc_q, instr_pc_d;
    logic        drop_q, drop_d;
    logic        instr_valid_q, instr_valid_d;
    logic        fetch_err_q, fetch_err_d;

    logic [31:0] redirect_target;
    logic        redirect_misaligned;

    assign redirect_target     = {redirect_pc[31:2], 2'b00};
    assign redirect_misaligned = |redirect_pc[1:0];

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        instr_d       = instr_q;
        instr_pc_d    = instr_pc_q;
        drop_d        = drop_q;
        instr_valid_d = instr_valid_q;
        fetch_err_d   = fetch_err_q;

        if (redirect) begin
            pc_d = redirect_target;
            if (redirect_misaligned) begin
                fetch_err_d = 1'b1;
            end
            case (state_q)
                IDLE: state_d = REQ;
                REQ: begin
                    // A request granted this cycle still carries the old address.
                    if (imem_gnt) begin
                        state_d = WAIT;
                        drop_d  = 1'b1;
                    end
                end
                WAIT: begin
                    if (imem_rvalid) begin
                        state_d = REQ;
                        drop_d  = 1'b0;
                    end else begin
                        drop_d  = 1'b1;
                    end
                end
                HOLD: begin
                    instr_valid_d = 1'b0;
                    state_d       = REQ;
                end
                default: state_d = IDLE;
            endcase
        end else begin
            case (state_q)
                IDLE: state_d = REQ;
                REQ: begin
                    if (imem_gnt) begin
                        state_d = WAIT;
                    end
                end
                WAIT: begin
                    if (imem_rvalid) begin
                        if (drop_q) begin
                            drop_d  = 1'b0;
                            state_d = REQ;
                        end else begin
                            instr_d       = imem_rdata;
                            instr_pc_d    = pc_q;
                            instr_valid_d = 1'b1;
                            pc_d          = pc_q + 32'd4;
                            state_d       = HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (instr_ready) begin
                        instr_valid_d = 1'b0;
                        state_d       = REQ;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q       <= IDLE;
            pc_q          <= RESET_PC;
            instr_q       <= 32'h0;
            instr_pc_q    <= 32'h0;
            drop_q        <= 1'b0;
            instr_valid_q <= 1'b0;
            fetch_err_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            instr_q       <= instr_d;
            instr_pc_q    <= instr_pc_d;
            drop_q        <= drop_d;
            instr_valid_q <= instr_valid_d;
            fetch_err_q   <= fetch_err_d;
        end
    end

    // The PC always names the next (or outstanding) fetch, so it doubles as the address.
    assign imem_req    = (state_q == REQ);
    assign imem_addr   = pc_q;
    assign instr_valid = instr_valid_q;
    assign instr       = instr_q;
    assign instr_pc    = instr_pc_q;
    assign fetch_err   = fetch_err_q;

endmodule
`default_nettype wire

// File: tb/tb_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_ctrl
// Description : Scoreboard bench for fetch_ctrl with directed fetch/redirect vectors.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_ctrl;

    localparam logic [31:0] C_KEY = 32'hA5A5_0000;

    logic        clk;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        fetch_err;

    int checks   = 0;
    int failures = 0;

    logic [31:0] exp_addr_q[$];
    logic [31:0] exp_pc_q[$];
    logic [31:0] exp_instr_q[$];

    fetch_ctrl #(.RESET_PC(32'h0000_0000)) dut (
        .clk        (clk),
        .rst        (rst),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_gnt   (imem_gnt),
        .imem_rvalid(imem_rvalid),
        .imem_rdata (imem_rdata),
        .instr_valid(instr_valid),
        .instr      (instr),
        .instr_pc   (instr_pc),
        .instr_ready(instr_ready),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .fetch_err  (fetch_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Monitor: grants and decode handshakes are compared against the queues.
    always @(negedge clk) begin
        if (rst && imem_req && imem_gnt) begin
            if (exp_addr_q.size() == 0) begin
                chk("unexpected_grant_addr", imem_addr, 32'hFFFF_FFFF);
            end else begin
                chk("grant_addr", imem_addr, exp_addr_q.pop_front());
            end
        end
        if (rst && instr_valid && instr_ready && !redirect) begin
            if (exp_pc_q.size() == 0) begin
                chk("unexpected_instr_pc", instr_pc, 32'hFFFF_FFFF);
            end else begin
                chk("deliver_pc", instr_pc, exp_pc_q.pop_front());
                chk("deliver_instr", instr, exp_instr_q.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_values();
        chk("rst_imem_req", {31'b0, imem_req}, 32'd0);
        chk("rst_imem_addr", imem_addr, 32'h0);
        chk("rst_instr_valid", {31'b0, instr_valid}, 32'd0);
        chk("rst_instr", instr, 32'h0);
        chk("rst_instr_pc", instr_pc, 32'h0);
        chk("rst_fetch_err", {31'b0, fetch_err}, 32'd0);
    endtask

    // Full fetch starting with the DUT in REQ at addr; leaves it in REQ at addr+4.
    task automatic fetch(input logic [31:0] addr, input int gnt_wait,
                         input int rv_wait, input int rdy_wait);
        exp_addr_q.push_back(addr);
        exp_pc_q.push_back(addr);
        exp_instr_q.push_back(addr ^ C_KEY);
        chk("req_before_gnt", {31'b0, imem_req}, 32'd1);
        chk("addr_before_gnt", imem_addr, addr);
        chk("valid_low_in_req", {31'b0, instr_valid}, 32'd0);
        for (int i = 0; i < gnt_wait; i++) begin
            tick();
            chk("stall_req", {31'b0, imem_req}, 32'd1);
            chk("stall_addr", imem_addr, addr);
        end
        imem_gnt = 1'b1;
        tick();
        imem_gnt = 1'b0;
        chk("req_low_in_wait", {31'b0, imem_req}, 32'd0);
        for (int i = 0; i < rv_wait; i++) begin
            tick();
            chk("wait_valid_low", {31'b0, instr_valid}, 32'd0);
        end
        imem_rvalid = 1'b1;
        imem_rdata  = addr ^ C_KEY;
        tick();
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0BAD_F00D;
        chk("hold_valid", {31'b0, instr_valid}, 32'd1);
        chk("hold_pc", instr_pc, addr);
        for (int i = 0; i < rdy_wait; i++) begin
            tick();
            chk("frozen_valid", {31'b0, instr_valid}, 32'd1);
            chk("frozen_instr", instr, addr ^ C_KEY);
            chk("frozen_pc", instr_pc, addr);
        end
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
    endtask

    task automatic expect_req_at(input string name, input logic [31:0] addr);
        chk({name, "_req"}, {31'b0, imem_req}, 32'd1);
        chk({name, "_addr"}, imem_addr, addr);
        chk({name, "_valid"}, {31'b0, instr_valid}, 32'd0);
    endtask

    initial begin
        rst         = 1'b0;
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
        instr_ready = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;

        repeat (3) tick();
        check_reset_values();
        rst = 1'b1;
        tick();
        expect_req_at("release", 32'h0);

        // Back-to-back minimum-latency sequential fetches.
        for (int i = 0; i < 4; i++) fetch(32'(i * 4), 0, 0, 0);
        chk("seq_fetch_err", {31'b0, fetch_err}, 32'd0);

        // Stalled grant and stalled decode, then a slower memory.
        fetch(32'h10, 5, 0, 4);
        fetch(32'h14, 0, 2, 0);

        // Redirect while waiting; stale response arrives three cycles later.
        exp_addr_q.push_back(32'h18);
        imem_gnt = 1'b1;
        tick();
        imem_gnt    = 1'b0;
        redirect    = 1'b1;
        redirect_pc = 32'h100;
        tick();
        redirect = 1'b0;
        tick();
        tick();
        chk("wait_redirect_valid", {31'b0, instr_valid}, 32'd0);
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hDEAD_BEEF;
        tick();
        imem_rvalid = 1'b0;
        expect_req_at("after_wait_redirect", 32'h100);
        fetch(32'h100, 0, 0, 0);

        // Redirect in HOLD with decode ready: held word is flushed, not consumed.
        exp_addr_q.push_back(32'h104);
        imem_gnt = 1'b1;
        tick();
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h104 ^ C_KEY;
        tick();
        imem_rvalid = 1'b0;
        chk("hold_before_flush", {31'b0, instr_valid}, 32'd1);
        redirect    = 1'b1;
        redirect_pc = 32'h40;
        instr_ready = 1'b1;
        tick();
        redirect    = 1'b0;
        instr_ready = 1'b0;
        expect_req_at("after_hold_redirect", 32'h40);

        // Redirect together with grant: the old-address response is dropped.
        exp_addr_q.push_back(32'h40);
        imem_gnt    = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 32'h80;
        tick();
        imem_gnt = 1'b0;
        redirect = 1'b0;
        chk("gnt_redirect_wait", {31'b0, imem_req}, 32'd0);
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h40 ^ C_KEY;
        tick();
        imem_rvalid = 1'b0;
        expect_req_at("after_gnt_redirect", 32'h80);
        fetch(32'h80, 0, 0, 0);

        // Two redirects while a drop is pending: last target wins, one drop.
        exp_addr_q.push_back(32'h84);
        imem_gnt = 1'b1;
        tick();
        imem_gnt    = 1'b0;
        redirect    = 1'b1;
        redirect_pc = 32'h300;
        tick();
        redirect_pc = 32'h310;
        tick();
        redirect    = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h1234_5678;
        tick();
        imem_rvalid = 1'b0;
        expect_req_at("after_double_redirect", 32'h310);
        fetch(32'h310, 0, 1, 0);

        // Misaligned target sets the sticky error; wrap at the top of memory.
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0206;
        tick();
        redirect = 1'b0;
        chk("misaligned_err", {31'b0, fetch_err}, 32'd1);
        expect_req_at("misaligned", 32'h204);
        fetch(32'h204, 0, 0, 0);
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        tick();
        redirect = 1'b0;
        expect_req_at("top_redirect", 32'hFFFF_FFFC);
        fetch(32'hFFFF_FFFC, 0, 0, 0);
        expect_req_at("wrap", 32'h0);
        fetch(32'h0, 0, 0, 0);
        chk("err_sticky", {31'b0, fetch_err}, 32'd1);

        // Reset during WAIT; a late response after release is ignored.
        exp_addr_q.push_back(32'h4);
        imem_gnt = 1'b1;
        tick();
        imem_gnt = 1'b0;
        rst      = 1'b0;
        tick();
        check_reset_values();
        rst = 1'b1;
        tick();
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hBAD0_BAD0;
        tick();
        imem_rvalid = 1'b0;
        expect_req_at("late_rvalid", 32'h0);
        chk("late_rvalid_instr", instr, 32'h0);
        chk("late_rvalid_err", {31'b0, fetch_err}, 32'd0);
        fetch(32'h0, 0, 0, 0);

        tick();
        chk("addr_queue_empty", 32'(exp_addr_q.size()), 32'd0);
        chk("instr_queue_empty", 32'(exp_pc_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
